// File: rtl/candle_flicker_driver.sv
// candle_flicker_driver: turns each lit candle bit into a flickering PWM LED drive.
// Build macro CANDLE_FADE_EN adds IGNITE/FADE brightness ramps; without it channels snap OFF<->BURN.
//
// state  | meaning
// -------+---------------------------------------------------------------
// OFF    | candle dark, duty held at 0
// IGNITE | ramping duty up by RAMP_STEP per tick (CANDLE_FADE_EN only)
// BURN   | duty = 255 - (random byte & FLICKER_MASK), refreshed every tick
// FADE   | ramping duty down by RAMP_STEP per tick (CANDLE_FADE_EN only)
module candle_flicker_driver #(
    parameter int unsigned UPDATE_DIV   = 390625,
    parameter int unsigned RAMP_STEP    = 8,
    parameter logic [7:0]  FLICKER_MASK = 8'h3F,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] candle_state,
    output logic [7:0] led,
    output logic [7:0] active_mask
);

    if (UPDATE_DIV < 2 || UPDATE_DIV > 2**24) begin : g_bad_div
        $error("candle_flicker_driver: UPDATE_DIV out of range");
    end
    if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_bad_step
        $error("candle_flicker_driver: RAMP_STEP out of range");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("candle_flicker_driver: LFSR_SEED must be nonzero");
    end

`ifdef CANDLE_FADE_EN
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_IGNITE = 2'd1,
        ST_BURN   = 2'd2,
        ST_FADE   = 2'd3
    } ch_state_t;
`else
    typedef enum logic {
        ST_OFF  = 1'b0,
        ST_BURN = 1'b1
    } ch_state_t;
`endif

    localparam logic [23:0] DIV_LAST = 24'(UPDATE_DIV - 1);

    function automatic logic [7:0] rot_low(input logic [15:0] x, input int unsigned k);
        return 8'((x << k) | (x >> (16 - k)));
    endfunction

    logic [7:0]  state_q;
    logic [7:0]  pwm_cnt;
    logic [23:0] div_cnt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic        tick;

    ch_state_t   ch_st   [8];
    ch_state_t   ch_st_d [8];
    logic [7:0]  duty    [8];
    logic [7:0]  duty_d  [8];
    logic [7:0]  flick   [8];

    assign tick     = (div_cnt == DIV_LAST);
    assign lfsr_nxt = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};

    // Each channel sees the same LFSR, rotated so neighbours flicker differently.
    for (genvar i = 0; i < 8; i++) begin : g_flick
        assign flick[i] = 8'hFF - (rot_low(lfsr, 2 * i) & FLICKER_MASK);
    end

`ifdef CANDLE_FADE_EN
    localparam logic [7:0] STEP8 = 8'(RAMP_STEP);

    logic [7:0] ramp_up [8];
    logic [7:0] ramp_dn [8];

    for (genvar i = 0; i < 8; i++) begin : g_ramp
        logic [8:0] sum;
        assign sum        = {1'b0, duty[i]} + {1'b0, STEP8};
        assign ramp_up[i] = sum[8] ? 8'hFF : sum[7:0];
        assign ramp_dn[i] = (duty[i] > STEP8) ? (duty[i] - STEP8) : 8'h00;
    end
`endif

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ch_st_d[i] = ch_st[i];
            duty_d[i]  = duty[i];
            if (tick) begin
`ifdef CANDLE_FADE_EN
                case (ch_st[i])
                    ST_OFF: begin
                        if (state_q[i]) ch_st_d[i] = ST_IGNITE;
                    end
                    ST_IGNITE: begin
                        if (!state_q[i]) begin
                            ch_st_d[i] = ST_FADE;
                        end else begin
                            duty_d[i] = ramp_up[i];
                            if (ramp_up[i] == 8'hFF) ch_st_d[i] = ST_BURN;
                        end
                    end
                    ST_BURN: begin
                        if (!state_q[i]) ch_st_d[i] = ST_FADE;
                        else             duty_d[i]  = flick[i];
                    end
                    ST_FADE: begin
                        if (state_q[i]) begin
                            ch_st_d[i] = ST_IGNITE;
                        end else begin
                            duty_d[i] = ramp_dn[i];
                            if (ramp_dn[i] == 8'h00) ch_st_d[i] = ST_OFF;
                        end
                    end
                    default: begin
                        ch_st_d[i] = ST_OFF;
                        duty_d[i]  = 8'h00;
                    end
                endcase
`else
                case (ch_st[i])
                    ST_OFF: begin
                        if (state_q[i]) begin
                            ch_st_d[i] = ST_BURN;
                            duty_d[i]  = flick[i];
                        end
                    end
                    ST_BURN: begin
                        if (!state_q[i]) begin
                            ch_st_d[i] = ST_OFF;
                            duty_d[i]  = 8'h00;
                        end else begin
                            duty_d[i]  = flick[i];
                        end
                    end
                    default: begin
                        ch_st_d[i] = ST_OFF;
                        duty_d[i]  = 8'h00;
                    end
                endcase
`endif
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= '0;
            pwm_cnt     <= '0;
            div_cnt     <= '0;
            lfsr        <= LFSR_SEED;
            led         <= '0;
            active_mask <= '0;
            for (int i = 0; i < 8; i++) begin
                ch_st[i] <= ST_OFF;
                duty[i]  <= '0;
            end
        end else begin
            state_q <= candle_state;
            pwm_cnt <= pwm_cnt + 8'd1;
            div_cnt <= tick ? 24'd0 : div_cnt + 24'd1;
            if (tick) lfsr <= lfsr_nxt;
            for (int i = 0; i < 8; i++) begin
                ch_st[i]       <= ch_st_d[i];
                duty[i]        <= duty_d[i];
                led[i]         <= (pwm_cnt < duty[i]);
                active_mask[i] <= (ch_st_d[i] != ST_OFF);
            end
        end
    end

endmodule

// File: tb/tb_candle_flicker_driver.sv
// tb_candle_flicker_driver: vector table, hand sequences and randomized stimulus
// checked cycle by cycle against a behavioural model of the flicker driver.
module tb_candle_flicker_driver;

    localparam int          D     = 4;
    localparam int          FMASK = 8'h3F;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          P_OFF = 0;
    localparam int          P_LIT = 2;
`ifdef CANDLE_FADE_EN
    localparam int          STEP     = 64;
    localparam int          P_RISE   = 1;
    localparam int          P_FALL   = 3;
    localparam int          OFF_WAIT = 6 * D;
`else
    localparam int          OFF_WAIT = D + 2;
`endif

    logic       sys_clk = 1'b0;
    logic       rst;
    logic [7:0] candle_state;
    logic [7:0] led;
    logic [7:0] active_mask;

    candle_flicker_driver #(
        .UPDATE_DIV  (D),
        .RAMP_STEP   (64),
        .FLICKER_MASK(8'h3F),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .candle_state(candle_state),
        .led         (led),
        .active_mask (active_mask)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    function automatic int rnd_byte(input logic [15:0] x, input int ch);
        int v;
        int k;
        v = int'(x);
        k = 2 * ch;
        return ((v << k) | (v >> (16 - k))) & 255;
    endfunction

    // Behavioural model: n counts edges since reset, so the update tick and
    // PWM phase follow directly from n.
    int          m_n;
    logic [7:0]  m_sq;
    logic [15:0] m_lfsr;
    int          m_duty [8];
    int          m_ph   [8];
    logic [7:0]  exp_led;
    logic [7:0]  exp_mask;
    bit          m_valid = 1'b0;
    bit          m_tick;
    int          flick;

    always @(posedge sys_clk) begin
        if (rst) begin
            m_n      = 0;
            m_sq     = '0;
            m_lfsr   = SEED;
            exp_led  = '0;
            exp_mask = '0;
            for (int i = 0; i < 8; i++) begin
                m_duty[i] = 0;
                m_ph[i]   = P_OFF;
            end
        end else begin
            m_tick = ((m_n % D) == D - 1);
            for (int i = 0; i < 8; i++) exp_led[i] = ((m_n % 256) < m_duty[i]);
            if (m_tick) begin
                for (int i = 0; i < 8; i++) begin
                    flick = 255 - (rnd_byte(m_lfsr, i) & FMASK);
`ifdef CANDLE_FADE_EN
                    case (m_ph[i])
                        P_OFF: if (m_sq[i]) m_ph[i] = P_RISE;
                        P_RISE: begin
                            if (!m_sq[i]) m_ph[i] = P_FALL;
                            else begin
                                m_duty[i] = (m_duty[i] + STEP > 255) ? 255 : m_duty[i] + STEP;
                                if (m_duty[i] == 255) m_ph[i] = P_LIT;
                            end
                        end
                        P_LIT: begin
                            if (!m_sq[i]) m_ph[i] = P_FALL;
                            else          m_duty[i] = flick;
                        end
                        default: begin
                            if (m_sq[i]) m_ph[i] = P_RISE;
                            else begin
                                m_duty[i] = (m_duty[i] - STEP < 0) ? 0 : m_duty[i] - STEP;
                                if (m_duty[i] == 0) m_ph[i] = P_OFF;
                            end
                        end
                    endcase
`else
                    m_ph[i]   = m_sq[i] ? P_LIT : P_OFF;
                    m_duty[i] = m_sq[i] ? flick : 0;
`endif
                end
                m_lfsr = lfsr_step(m_lfsr);
            end
            for (int i = 0; i < 8; i++) exp_mask[i] = (m_ph[i] != P_OFF);
            m_sq = candle_state;
            m_n++;
        end
        m_valid = 1'b1;
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            check("model_led", {8'h00, led}, {8'h00, exp_led});
            check("model_active_mask", {8'h00, active_mask}, {8'h00, exp_mask});
        end
    end

    typedef struct {
        logic [7:0] pattern;
        int         hold;
        logic [7:0] exp_mask;
        logic [7:0] dark;
    } vec_t;

    vec_t vecs [9];
    bit   found;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        candle_state = 8'hFF;

        vecs[0] = '{8'h01, 40, 8'h01, 8'hFE};
        vecs[1] = '{8'hFF, 40, 8'hFF, 8'h00};
`ifdef CANDLE_FADE_EN
        vecs[2] = '{8'h00,  6, 8'hFF, 8'h00};
`else
        vecs[2] = '{8'h00,  6, 8'h00, 8'hFF};
`endif
        vecs[3] = '{8'h00, 40, 8'h00, 8'hFF};
        vecs[4] = '{8'h0F, 40, 8'h0F, 8'hF0};
        vecs[5] = '{8'hF0, 40, 8'hF0, 8'h0F};
        vecs[6] = '{8'hAA, 40, 8'hAA, 8'h55};
        vecs[7] = '{8'h55, 40, 8'h55, 8'hAA};
        vecs[8] = '{8'h00, 40, 8'h00, 8'hFF};

        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        #1;
        check("lfsr_seed", dut.lfsr, SEED);

        for (int v = 0; v < 9; v++) begin
            candle_state = vecs[v].pattern;
            repeat (vecs[v].hold) @(negedge sys_clk);
            check("vec_mask", {8'h00, active_mask}, {8'h00, vecs[v].exp_mask});
            check("vec_dark", {8'h00, led & vecs[v].dark}, 16'h0000);
        end

        // A pulse that lives entirely between two ticks must leave no trace.
        begin : glitch
            int guard;
            guard = 0;
            while ((m_n % D) != 0 && guard < 8) begin
                @(negedge sys_clk);
                guard++;
            end
            candle_state = 8'hFF;
            @(negedge sys_clk);
            candle_state = 8'h00;
            repeat (2 * D) begin
                @(negedge sys_clk);
                check("glitch_mask", {8'h00, active_mask}, 16'h0000);
                check("glitch_led", {8'h00, led}, 16'h0000);
            end
        end

        candle_state = 8'h01;
        found = 1'b0;
        for (int k = 0; k < D + 2 && !found; k++) begin
            @(negedge sys_clk);
            if (active_mask == 8'h01) found = 1'b1;
        end
        check("ignite_mask_first_tick", {15'd0, found}, 16'd1);
        repeat (40) @(negedge sys_clk);
        candle_state = 8'h00;
        repeat (40) @(negedge sys_clk);

`ifdef CANDLE_FADE_EN
        candle_state = 8'hFF;
        repeat (16) begin
            @(negedge sys_clk);
            check("sync_led", {15'd0, (led == 8'h00 || led == 8'hFF)}, 16'd1);
            check("sync_mask", {15'd0, (active_mask == 8'h00 || active_mask == 8'hFF)}, 16'd1);
        end
        repeat (24) @(negedge sys_clk);
        check("sync_burn_mask", {8'h00, active_mask}, 16'h00FF);
        candle_state = 8'h00;
        repeat (40) @(negedge sys_clk);
`endif

        candle_state = 8'h20;
        repeat (40) @(negedge sys_clk);
        check("ch5_burn_mask", {8'h00, active_mask}, 16'h0020);
        candle_state = 8'h00;
        repeat (OFF_WAIT) @(negedge sys_clk);
        repeat (8) begin
            check("ch5_dark_led", {15'd0, led[5]}, 16'd0);
            check("ch5_dark_mask", {8'h00, active_mask}, 16'h0000);
            @(negedge sys_clk);
        end

        for (int r = 0; r < 90; r++) begin
            if (r % 30 == 29) begin
                rst = 1'b1;
                repeat (2) @(negedge sys_clk);
                rst = 1'b0;
            end
            candle_state = 8'($urandom);
            repeat ($urandom_range(1, 24)) @(negedge sys_clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
